// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA multi-precision multiply datapath.
package rsa_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LIMBS = 4;

    // Widest operand the limb helper can address.
    localparam int MAX_OPW = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Aligns limb 'idx' of a zero-extended operand to bit 0; the caller
    // keeps the low 'width' bits with a size cast.
    function automatic logic [MAX_OPW-1:0] limb_sel(
        input logic [MAX_OPW-1:0] vec,
        input int unsigned        idx,
        input int unsigned        width
    );
        return vec >> (idx * width);
    endfunction

endpackage

// File: rtl/mp_mul_retire_pipe.sv
// Two-stage valid/tag delay line matching the external multiplier latency.
module mp_mul_retire_pipe #(
    parameter int TW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_vld_i,
    input  logic [TW-1:0] in_tag_i,
    output logic          out_vld_o,
    output logic [TW-1:0] out_tag_o
);

    logic [1:0]    vld_q;
    logic [TW-1:0] tag0_q;
    logic [TW-1:0] tag1_q;

    // Shift valid and tag along with the product travelling through the multiplier.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            tag0_q <= '0;
            tag1_q <= '0;
        end else begin
            vld_q  <= {vld_q[0], in_vld_i};
            tag0_q <= in_tag_i;
            tag1_q <= tag0_q;
        end
    end

    assign out_vld_o = vld_q[1];
    assign out_tag_o = tag1_q;

endmodule

// File: rtl/mp_mul_sched.sv
// Multi-precision multiply scheduler: issues every limb pair to an external
// 2-cycle pipelined multiplier and accumulates the returned partial products.
module mp_mul_sched
    import rsa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMBS = DEF_LIMBS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LIMBS*WIDTH-1:0]   op_a,
    input  logic [LIMBS*WIDTH-1:0]   op_b,
    output logic                     busy,
    output logic                     done,
    output logic [2*LIMBS*WIDTH-1:0] result,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [WIDTH-1:0]         mul_lo,
    input  logic [WIDTH-1:0]         mul_hi
);

    localparam int OPW   = LIMBS * WIDTH;
    localparam int RW    = 2 * OPW;
    localparam int NPAIR = LIMBS * LIMBS;
    localparam int KW    = $clog2(NPAIR + 1);
    localparam int TW    = $clog2(2 * LIMBS);

    state_t           state_q, state_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    r_q, r_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic             iss_vld_q, iss_vld_d;
    logic [TW-1:0]    iss_tag_q, iss_tag_d;

    logic             ret_vld;
    logic [TW-1:0]    ret_tag;

    logic [MAX_OPW-1:0] src_a, src_b;
    logic [31:0]        kk, ii, jj;
    logic [WIDTH-1:0]   pair_a, pair_b;
    logic [TW-1:0]      pair_tag;

    logic [RW-1:0]      prod_ext;
    logic [31:0]        shamt;

    mp_mul_retire_pipe #(
        .TW (TW)
    ) u_retire (
        .clk_i     (clk),
        .rst_i     (rst),
        .in_vld_i  (iss_vld_q),
        .in_tag_i  (iss_tag_q),
        .out_vld_o (ret_vld),
        .out_tag_o (ret_tag)
    );

    // Select the next limb pair; the first pair comes straight from the ports
    // so it reaches the multiplier in the cycle right after the accepted start.
    always_comb begin
        src_a = '0;
        src_b = '0;
        if (state_q == ST_ISSUE) begin
            src_a[OPW-1:0] = a_q;
            src_b[OPW-1:0] = b_q;
            kk             = 32'(k_q);
        end else begin
            src_a[OPW-1:0] = op_a;
            src_b[OPW-1:0] = op_b;
            kk             = '0;
        end
        ii       = kk / LIMBS;
        jj       = kk % LIMBS;
        pair_a   = WIDTH'(limb_sel(src_a, jj, WIDTH));
        pair_b   = WIDTH'(limb_sel(src_b, ii, WIDTH));
        pair_tag = TW'(ii + jj);
    end

    // Position the returning product at limb offset (i+j) for the accumulator.
    always_comb begin
        prod_ext              = '0;
        prod_ext[2*WIDTH-1:0] = {mul_hi, mul_lo};
        shamt                 = 32'(ret_tag) * WIDTH;
    end

    // Next-state, issue and accumulate logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        r_d       = r_q;
        acc_d     = acc_q;
        mul_a_d   = '0;
        mul_b_d   = '0;
        iss_vld_d = 1'b0;
        iss_tag_d = '0;

        if (ret_vld) begin
            acc_d = acc_q + (prod_ext << shamt);
            r_d   = r_q + KW'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d       = op_a;
                    b_d       = op_b;
                    acc_d     = '0;
                    r_d       = '0;
                    k_d       = KW'(1);
                    mul_a_d   = pair_a;
                    mul_b_d   = pair_b;
                    iss_vld_d = 1'b1;
                    iss_tag_d = pair_tag;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (k_q == KW'(NPAIR)) begin
                    state_d = ST_DRAIN;
                end else begin
                    mul_a_d   = pair_a;
                    mul_b_d   = pair_b;
                    iss_vld_d = 1'b1;
                    iss_tag_d = pair_tag;
                    k_d       = k_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                if (ret_vld && (r_q == KW'(NPAIR - 1))) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            r_q       <= '0;
            acc_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            iss_vld_q <= 1'b0;
            iss_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            k_q       <= k_d;
            r_q       <= r_d;
            acc_q     <= acc_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            iss_vld_q <= iss_vld_d;
            iss_tag_q <= iss_tag_d;
        end
    end

    assign busy   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done   = (state_q == ST_DONE);
    assign result = acc_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_mp_mul_sched.sv
// Scoreboard bench for mp_mul_sched with a 2-cycle pipelined multiplier model.
module tb_mp_mul_sched;

    localparam int W   = 32;
    localparam int L   = 4;
    localparam int OPW = L * W;
    localparam int RW  = 2 * OPW;
    // done is visible in the cycle opened by this many edges after the accept edge
    localparam int LAT = L * L + 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [OPW-1:0] op_a, op_b;
    logic           busy, done;
    logic [RW-1:0]  result;
    logic [W-1:0]   mul_a, mul_b, mul_lo, mul_hi;
    logic [2*W-1:0] p1, p2;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [RW-1:0] prod;
        int            done_at;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // external multiplier: two register stages, no stall
    always @(posedge clk) begin
        p1 <= 64'(mul_a) * 64'(mul_b);
        p2 <= p1;
    end
    assign mul_lo = p2[W-1:0];
    assign mul_hi = p2[2*W-1:W];

    mp_mul_sched #(
        .WIDTH (W),
        .LIMBS (L)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .mul_a  (mul_a),
        .mul_b  (mul_b),
        .mul_lo (mul_lo),
        .mul_hi (mul_hi)
    );

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    endtask

    // Called just after a negedge with the DUT able to accept; returns #1 after the accept edge.
    task automatic start_run(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                             input logic [RW-1:0] prod, input bit track, input bit hold);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        if (track) sb.push_back('{prod, cyc + LAT});
        if (!hold) start = 1'b0;
    endtask

    // Returns at the negedge inside the done cycle, counting busy cycles before it.
    task automatic wait_done(output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
        chk("done_seen", RW'(seen), RW'(1));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 at edge %0d, expected no pending run", cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.prod);
                chk("done_cycle", RW'(cyc), RW'(e.done_at));
                chk("busy_in_done", RW'(busy), RW'(0));
                chk("mul_idle", RW'({mul_a, mul_b}), RW'(0));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int             nb;
        logic [OPW-1:0] ra, rb;
        logic [OPW-1:0] ones;
        ones  = '1;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", RW'(busy), RW'(0));
        chk("rst_done", RW'(done), RW'(0));
        chk("rst_result", result, RW'(0));
        chk("rst_mul", RW'({mul_a, mul_b}), RW'(0));
        rst = 1'b0;

        // zero operand, busy for cycles 1..18
        start_run('0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEBABE, '0, 1'b1, 1'b0);
        wait_done(nb);
        chk("busy_cycles", RW'(nb), RW'(18));

        // identity, one idle cycle after done
        @(negedge clk);
        start_run(128'h1, ones, {128'h0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF}, 1'b1, 1'b0);
        wait_done(nb);

        // carry stress, started in the done cycle
        start_run(ones, ones,
                  256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001,
                  1'b1, 1'b0);
        wait_done(nb);

        // second start in the done cycle
        start_run(128'd7, 128'd9, 256'h3F, 1'b1, 1'b0);
        wait_done(nb);

        // start held for the whole run, op_a changed mid-run
        @(negedge clk);
        start_run(128'h1_00000000, 128'h5, 256'h5_00000000, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        op_a = ones;
        wait_done(nb);
        start = 1'b0;

        // reset at cycle 7 of a run: no done may follow
        @(negedge clk);
        start_run(128'h11111111_22222222_33333333_44444444,
                  128'h55555555_66666666_77777777_88888888, '0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", RW'(busy), RW'(0));
        chk("midrst_done", RW'(done), RW'(0));
        chk("midrst_result", result, RW'(0));
        chk("midrst_mul", RW'({mul_a, mul_b}), RW'(0));
        rst = 1'b0;
        repeat (30) @(negedge clk);
        start_run(128'd3, 128'd5, 256'd15, 1'b1, 1'b0);
        wait_done(nb);

        // back-to-back random runs against a wide reference product
        for (int r = 0; r < 1000; r++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            start_run(ra, rb, RW'(ra) * RW'(rb), 1'b1, 1'b0);
            wait_done(nb);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", RW'(sb.size()), RW'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mp_mul_sched.md
Name: mp_mul_sched

Overview:
Multi-precision multiply scheduler for the RSA datapath. It takes two LIMBS×WIDTH-bit operands and issues every limb pair to the external pipelined WIDTH×WIDTH multiplier, one pair per cycle. It consumes the low and high product halves returned two cycles later and accumulates them, with carry, into a 2·LIMBS×WIDTH-bit product register. It sits directly around the multiplier: it drives the multiplier's inputs and consumes its outputs.

Parameters:
WIDTH, 32, limb width; must equal the multiplier's WIDTH
LIMBS, 4, limbs per operand (operand width = LIMBS*WIDTH)

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op_a  input  LIMBS*WIDTH  operand A, sampled on the accepted-start edge
op_b  input  LIMBS*WIDTH  operand B, sampled on the accepted-start edge
busy  output  1  high from the cycle after an accepted start through the last accumulate cycle
done  output  1  one-cycle pulse when result is final
result  output  2*LIMBS*WIDTH  product A*B; stable from done until the next accepted start
mul_a  output  WIDTH  limb to multiplier inp_1 (registered)
mul_b  output  WIDTH  limb to multiplier inp_2 (registered)
mul_lo  input  WIDTH  multiplier out_l
mul_hi  input  WIDTH  multiplier out_h

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; busy=0, done=0.
  - result=0, mul_a=0, mul_b=0.
  - Issue and retire counters are cleared, and the in-flight valid pipe is cleared.
- Multiplier contract: a pair driven on mul_a/mul_b during cycle c appears on mul_lo/mul_hi during cycle c+2. The latency is fixed, with no stall or handshake.
- Accepted start (cycle 0):
  - Condition: start=1 at a posedge while in IDLE.
  - Latch op_a and op_b, clear the accumulator, enter ISSUE.
- ISSUE state:
  - Runs for LIMBS*LIMBS cycles, cycles 1..LIMBS².
  - Issue index k runs 0..LIMBS²-1, with i = k / LIMBS and j = k % LIMBS.
  - Drive mul_a = A[j], mul_b = B[i].
  - Push the tag (i+j) into a 2-deep valid/tag delay pipe.
- Retire:
  - When the pipe output is valid in cycle c+2, add {mul_hi, mul_lo} << ((i+j)*WIDTH) to the accumulator at that cycle's edge.
  - The addition is a full-width 2*LIMBS*WIDTH-bit add, so carry propagates through all upper limbs in one cycle.
  - No overflow is possible; the final sum is < 2^(2*LIMBS*WIDTH).
- DRAIN state: entered after the last issue. It lasts 2 cycles, with no new issues and mul_a/mul_b=0, while the last two products retire.
- DONE:
  - done=1 for exactly one cycle, cycle LIMBS²+3 after the start edge (cycle 19 for LIMBS=4).
  - State returns to IDLE in that same cycle.
  - busy=0 during the done cycle.
- Total latency: LIMBS²+3 cycles from the accepted-start edge to done.
- start while busy=1: ignored; operands are not resampled and the run is unaffected.
- start during the done cycle: accepted; the new run begins and result clears on the following edge.
- rst mid-run: aborts immediately to the reset values. No done is generated, and in-flight products are discarded.
- mul_a/mul_b: 0 whenever not in ISSUE.

Decomposition:
- Shared package rsa_pkg holds:
  - the state encoding (IDLE, ISSUE, DRAIN, DONE);
  - the WIDTH/LIMBS defaults;
  - a limb-select helper function.
- One natural sub-module: mp_mul_retire_pipe, the 2-stage valid+tag delay line matched to the multiplier latency.
- The multiplier itself is instantiated by the parent, not inside this block.

Test Plan:
- Bench setup: WIDTH=32, LIMBS=4, with the real multiplier connected.
- Zero operand: A=0, B=0xDEADBEEF_01234567_89ABCDEF_CAFEBABE -> result=0; done exactly at cycle 19; busy high for cycles 1..18.
- Identity: A=1, B=0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF -> result upper 128 bits=0, lower 128 bits=B.
- Carry stress: A=B=2^128-1 -> result=0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001.
- Handshake:
  - start held high for the whole run with op_a changed at cycle 5 -> result uses the cycle-0 operands.
  - start asserted in the done cycle -> second run accepted; done again 19 cycles later.
- Reset mid-run: rst at cycle 7 -> next cycle busy=0, done=0, result=0, and no done pulse ever appears. A following run with A=3, B=5 -> result=15.
- Random: 1000 back-to-back runs with random A/B, compared against a reference big-integer product; done-to-start spacing of 0 and 1 cycles.
